// File: rtl/program_loader.sv
// Program-memory writer for picoMIPS: packs CHUNK-bit words into instructions and
// writes them to sequential addresses. Optional feature: PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int N      = 8,
    parameter int O_SIZE = 6,
    parameter int R_SIZE = 3,
    parameter int P_SIZE = 5,
    parameter int I_SIZE = O_SIZE + R_SIZE + N,
    parameter int CHUNK  = 8
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              loadReq,
    input  logic              loadDone,
    input  logic [CHUNK-1:0]  dataIn,
    input  logic              dataValid,
    output logic              dataReady,
    output logic              pmWriteEn,
    output logic [P_SIZE-1:0] pmWriteAddr,
    output logic [I_SIZE-1:0] pmWriteData,
    output logic              cpuHold,
    output logic              pcReset,
    output logic [P_SIZE:0]   wordCount,
    output logic              loadError
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    ,
    output logic [I_SIZE-1:0] checksum
`endif
);

    localparam int NCHUNK = (I_SIZE + CHUNK - 1) / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0]     LAST_CHUNK = CW'(NCHUNK - 1);
    localparam logic [P_SIZE-1:0] ADDR_MAX   = '1;

    typedef enum logic [1:0] {RUN, LOAD, WRITE, FINISH} state_t;

    state_t              state, state_nxt;
    logic [CW-1:0]       chunk;
    logic [P_SIZE-1:0]   addr;
    logic [I_SIZE-1:0]   shift;
    logic [P_SIZE:0]     count;
    logic                err;
    logic                done_pending;
    logic                complete;

    assign complete = (state == LOAD) && dataValid && (chunk == LAST_CHUNK);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Control outputs decode only the registered state, so no input reaches an output
    always_comb begin
        state_nxt = state;
        dataReady = 1'b0;
        pmWriteEn = 1'b0;
        cpuHold   = 1'b0;
        pcReset   = 1'b0;
        case (state)
            RUN: begin
                if (loadReq) state_nxt = LOAD;
            end
            LOAD: begin
                cpuHold   = 1'b1;
                dataReady = 1'b1;
                if (complete)      state_nxt = WRITE;
                else if (loadDone) state_nxt = FINISH;
            end
            WRITE: begin
                cpuHold   = 1'b1;
                pmWriteEn = 1'b1;
                if ((addr == ADDR_MAX) || done_pending || loadDone) state_nxt = FINISH;
                else                                                state_nxt = LOAD;
            end
            FINISH: begin
                cpuHold   = 1'b1;
                pcReset   = 1'b1;
                state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            chunk        <= '0;
            addr         <= '0;
            shift        <= '0;
            count        <= '0;
            err          <= 1'b0;
            done_pending <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (loadReq) begin
                        chunk        <= '0;
                        addr         <= '0;
                        count        <= '0;
                        err          <= 1'b0;
                        done_pending <= 1'b0;
                    end
                end
                LOAD: begin
                    if (dataValid) begin
                        // Only the low I_SIZE bits are kept, dropping the excess MSBs
                        shift <= I_SIZE'({shift, dataIn});
                        if (chunk == LAST_CHUNK) begin
                            chunk        <= '0;
                            done_pending <= loadDone;
                        end else begin
                            chunk <= chunk + 1'b1;
                        end
                    end
                    if (loadDone && !complete) begin
                        chunk <= '0;
                        if ((chunk != '0) || dataValid) err <= 1'b1;
                    end
                end
                WRITE: begin
                    count        <= count + 1'b1;
                    done_pending <= 1'b0;
                    if (addr != ADDR_MAX) addr <= addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            checksum <= '0;
        end else if ((state == RUN) && loadReq) begin
            checksum <= '0;
        end else if (state == WRITE) begin
            checksum <= checksum ^ shift;
        end
    end
`endif

    assign pmWriteAddr = addr;
    assign pmWriteData = shift;
    assign wordCount   = count;
    assign loadError   = err;

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader; checksum checks only when
// PROGRAM_LOADER_CHECKSUM_EN is defined.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic        loadReq = 1'b0;
    logic        loadDone = 1'b0;
    logic [7:0]  dataIn = 8'h00;
    logic        dataValid = 1'b0;
    logic        dataReady;
    logic        pmWriteEn;
    logic [4:0]  pmWriteAddr;
    logic [16:0] pmWriteData;
    logic        cpuHold;
    logic        pcReset;
    logic [5:0]  wordCount;
    logic        loadError;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [16:0] checksum;
`endif

    int total = 0;
    int bad = 0;

    program_loader dut (
        .clk(clk),
        .nReset(nReset),
        .loadReq(loadReq),
        .loadDone(loadDone),
        .dataIn(dataIn),
        .dataValid(dataValid),
        .dataReady(dataReady),
        .pmWriteEn(pmWriteEn),
        .pmWriteAddr(pmWriteAddr),
        .pmWriteData(pmWriteData),
        .cpuHold(cpuHold),
        .pcReset(pcReset),
        .wordCount(wordCount),
        .loadError(loadError)
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ,
        .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic done);
        dataIn    = d;
        dataValid = 1'b1;
        loadDone  = done;
        tick();
        dataValid = 1'b0;
        loadDone  = 1'b0;
    endtask

    task automatic start_session();
        loadReq = 1'b1;
        tick();
        loadReq = 1'b0;
    endtask

    task automatic end_session();
        loadDone = 1'b1;
        tick();
        loadDone = 1'b0;
    endtask

    initial begin
        // Reset held, then released
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_cpuHold", cpuHold, 0);
        nReset = 1'b1;
        tick();
        check("rst_cpuHold", cpuHold, 0);
        check("rst_dataReady", dataReady, 0);
        check("rst_pmWriteEn", pmWriteEn, 0);
        check("rst_pcReset", pcReset, 0);
        check("rst_addr", pmWriteAddr, 0);
        check("rst_data", pmWriteData, 0);
        check("rst_wordCount", wordCount, 0);
        check("rst_loadError", loadError, 0);

        // dataValid in RUN is ignored
        for (int i = 0; i < 3; i++) begin
            send(8'hAA, 1'b0);
            check($sformatf("run_ignore_we%0d", i), pmWriteEn, 0);
            check($sformatf("run_ignore_rdy%0d", i), dataReady, 0);
        end

        // Single word 0x12345
        start_session();
        check("t2_cpuHold", cpuHold, 1);
        check("t2_dataReady", dataReady, 1);
        send(8'h01, 1'b0);
        send(8'h23, 1'b0);
        check("t2_no_early_we", pmWriteEn, 0);
        send(8'h45, 1'b0);
        check("t2_we", pmWriteEn, 1);
        check("t2_addr", pmWriteAddr, 0);
        check("t2_data", pmWriteData, 17'h12345);
        check("t2_rdy_in_write", dataReady, 0);
        tick();
        check("t2_we_one_cycle", pmWriteEn, 0);
        check("t2_wordCount", wordCount, 1);
        end_session();
        check("t2_pcReset", pcReset, 1);
        tick();
        check("t2_pcReset_fall", pcReset, 0);
        check("t2_cpuHold_fall", cpuHold, 0);

        // Two words then loadDone
        start_session();
        check("t3_wordCount_clr", wordCount, 0);
        send(8'h00, 1'b0);
        send(8'h0F, 1'b0);
        send(8'hF0, 1'b0);
        check("t3_w0_we", pmWriteEn, 1);
        check("t3_w0_addr", pmWriteAddr, 0);
        check("t3_w0_data", pmWriteData, 17'h00FF0);
        tick();
        send(8'h1F, 1'b0);
        send(8'hFF, 1'b0);
        send(8'hFE, 1'b0);
        check("t3_w1_we", pmWriteEn, 1);
        check("t3_w1_addr", pmWriteAddr, 1);
        check("t3_w1_data", pmWriteData, 17'h1FFFE);
        tick();
        end_session();
        check("t3_pcReset", pcReset, 1);
        check("t3_cpuHold_finish", cpuHold, 1);
        tick();
        check("t3_pcReset_fall", pcReset, 0);
        check("t3_cpuHold_fall", cpuHold, 0);
        check("t3_wordCount", wordCount, 2);
        check("t3_loadError", loadError, 0);

        // Partial instruction dropped
        start_session();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        end_session();
        check("t4_no_write", pmWriteEn, 0);
        check("t4_pcReset", pcReset, 1);
        check("t4_loadError", loadError, 1);
        check("t4_wordCount", wordCount, 0);
        tick();
        check("t4_loadError_sticky", loadError, 1);
        start_session();
        check("t4_loadError_clr", loadError, 0);

        // Fill all 32 addresses; auto FINISH after the last
        for (int i = 0; i < 32; i++) begin
            send(8'h00, 1'b0);
            send(8'(i), 1'b0);
            send(8'h5A, 1'b0);
            check($sformatf("t5_we%0d", i), pmWriteEn, 1);
            check($sformatf("t5_addr%0d", i), pmWriteAddr, i);
            check($sformatf("t5_data%0d", i), pmWriteData, (i << 8) | 32'h5A);
            tick();
            if (i < 31) check($sformatf("t5_rdy%0d", i), dataReady, 1);
        end
        check("t5_auto_pcReset", pcReset, 1);
        check("t5_wordCount", wordCount, 32);
        check("t5_no_wrap", pmWriteAddr, 31);
        tick();
        check("t5_cpuHold_fall", cpuHold, 0);

        // Completing chunk coincident with loadDone
        start_session();
        send(8'h00, 1'b0);
        send(8'h0F, 1'b0);
        send(8'hF0, 1'b0);
        tick();
        send(8'h01, 1'b0);
        send(8'h23, 1'b0);
        send(8'h45, 1'b1);
        check("t6_we", pmWriteEn, 1);
        check("t6_addr", pmWriteAddr, 1);
        check("t6_data", pmWriteData, 17'h12345);
        tick();
        check("t6_pcReset", pcReset, 1);
        tick();
        check("t6_cpuHold_fall", cpuHold, 0);
        check("t6_wordCount", wordCount, 2);
        check("t6_loadError", loadError, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        check("t6_checksum", checksum, 17'h12345 ^ 17'h00FF0);
`endif

        // Asynchronous reset in the middle of a session
        start_session();
        send(8'h77, 1'b0);
        check("t7_in_load", cpuHold, 1);
        #2;
        nReset = 1'b0;
        #1;
        check("t7_async_cpuHold", cpuHold, 0);
        check("t7_async_dataReady", dataReady, 0);
        check("t7_async_wordCount", wordCount, 0);
        @(posedge clk);
        #1;
        nReset = 1'b1;
        tick();
        check("t7_run_dataReady", dataReady, 0);
        check("t7_run_data", pmWriteData, 0);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        check("t7_checksum", checksum, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
